// File: rtl/hil_timer_pkg.sv
// Shared definitions for the HIL timer blocks: state encodings and the
// default counter width used when a timer is instantiated without overrides.
package hil_timer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      HOLD    = 2'd2,
      EXPIRED = 2'd3
   } timer_state_t;

endpackage : hil_timer_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counting timer. Counts enable-qualified ticks down from a
// programmed reload value, emits a one-cycle done pulse at each terminal
// event and either auto-reloads (periodic) or parks in EXPIRED (one-shot).
module countdown_timer
   import hil_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             periodic,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             expired
);

   timer_state_t     state;
   timer_state_t     next_state;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] reload_next;
   logic             done_next;
   logic             expired_next;
   logic             reload_nonzero;
   logic             count_is_one;

   assign reload_nonzero = (reload != '0);
   assign count_is_one   = (count == WIDTH'(1));

   // State register plus the datapath registers that move with it; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         reload  <= '0;
         done    <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= next_state;
         count   <= count_next;
         reload  <= reload_next;
         done    <= done_next;
         expired <= expired_next;
      end
   end

   // Next-state and datapath decisions, honouring load > stop > start > enable.
   always_comb begin
      next_state   = state;
      count_next   = count;
      reload_next  = reload;
      done_next    = 1'b0;
      expired_next = expired;

      if (load) begin
         reload_next  = load_value;
         count_next   = load_value;
         next_state   = IDLE;
         expired_next = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!stop && start && reload_nonzero) begin
                  next_state = RUN;
               end
            end

            RUN: begin
               if (stop) begin
                  next_state = HOLD;
               end else if (enable) begin
                  if (count_is_one) begin
                     done_next = 1'b1;
                     if (periodic) begin
                        count_next = reload;
                     end else begin
                        count_next   = '0;
                        expired_next = 1'b1;
                        next_state   = EXPIRED;
                     end
                  end else if (count != '0) begin
                     count_next = count - WIDTH'(1);
                  end
               end
            end

            HOLD: begin
               if (!stop && start) begin
                  next_state = RUN;
               end
            end

            EXPIRED: begin
               if (!stop && start && reload_nonzero) begin
                  count_next   = reload;
                  expired_next = 1'b0;
                  next_state   = RUN;
               end
            end

            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   // Output decode: busy follows the registered state directly.
   always_comb begin
      busy = (state == RUN);
   end

endmodule : countdown_timer
